// File: rtl/sr_latch_ctrl_if.sv
// sr_latch_ctrl_if -- bundle between two latch-write requesters, the gated
// SR latch and the sr_latch_ctrl sequencer.
//   req_a/cmd_a/gnt_a, req_b/cmd_b/gnt_b : requester handshakes (cmd 1=set)
//   s, r, en                             : drive to the gated SR latch
//   q, qbar                              : latch outputs read back
//   clr_err                              : clears the sticky err flag
//   busy, err, state_q                   : status (state_q = last verified value)
// master = environment side (requesters + latch), slave = controller.
interface sr_latch_ctrl_if;
  logic req_a, cmd_a, gnt_a;
  logic req_b, cmd_b, gnt_b;
  logic s, r, en;
  logic q, qbar;
  logic clr_err;
  logic busy, err, state_q;

  modport master (
    output req_a, cmd_a, req_b, cmd_b, q, qbar, clr_err,
    input  gnt_a, gnt_b, s, r, en, busy, err, state_q
  );

  modport slave (
    input  req_a, cmd_a, req_b, cmd_b, q, qbar, clr_err,
    output gnt_a, gnt_b, s, r, en, busy, err, state_q
  );
endinterface

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl -- arbitrates two requesters for write access to a gated SR
// latch, drives a fixed-length set/reset pulse, waits for it to settle, then
// reads the latch back and either records the value or flags an error.
//   clk     : single clock, rising edge
//   rst_n   : synchronous active-low reset
//   bus     : sr_latch_ctrl_if.slave (handshakes, latch drive/readback, status)
// Parameters: PULSE_CYC (1..255) drive cycles, SETTLE_CYC (1..255) settle cycles.
// Grant latency from the arbitration edge is 1+PULSE_CYC+SETTLE_CYC cycles.
module sr_latch_ctrl #(
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic           clk,
  input logic           rst_n,
  sr_latch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} st_e;

  localparam logic [7:0] PulseLd  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] SettleLd = 8'(SETTLE_CYC - 1);

  st_e        st_q;
  logic [7:0] cnt_q;
  logic       win_q;     // current owner: 0=A, 1=B
  logic       cmd_q;     // command frozen at arbitration
  logic       last_q;    // last granted requester, drives round-robin
  logic       s_q, r_q, en_q;
  logic       gnt_a_q, gnt_b_q;
  logic       err_q, val_q;

  logic win_d, cmd_d, match;

  // Contention goes to whoever was not served last; a lone request just wins.
  assign win_d = (bus.req_a && bus.req_b) ? ~last_q : bus.req_b;
  assign cmd_d = win_d ? bus.cmd_b : bus.cmd_a;
  assign match = (bus.q == cmd_q) && (bus.qbar == ~cmd_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cnt_q   <= 8'd0;
      win_q   <= 1'b0;
      cmd_q   <= 1'b0;
      last_q  <= 1'b1;   // so the first contended arbitration favours A
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      en_q    <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            st_q   <= DRIVE;
            cnt_q  <= PulseLd;
            win_q  <= win_d;
            last_q <= win_d;
            cmd_q  <= cmd_d;
            // drive outputs are registered, so load them on DRIVE entry
            s_q    <= cmd_d;
            r_q    <= ~cmd_d;
            en_q   <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == 8'd0) begin
            st_q  <= SETTLE;
            cnt_q <= SettleLd;
            s_q   <= 1'b0;
            r_q   <= 1'b0;
            en_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        SETTLE: begin
          if (cnt_q == 8'd0) begin
            st_q    <= CHECK;
            cnt_q   <= 8'd0;
            gnt_a_q <= ~win_q;
            gnt_b_q <= win_q;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        CHECK: begin
          st_q    <= IDLE;
          cnt_q   <= 8'd0;
          gnt_a_q <= 1'b0;
          gnt_b_q <= 1'b0;
          if (match) val_q <= cmd_q;
        end
        default: st_q <= IDLE;
      endcase
      // a mismatch outranks a simultaneous clear
      if (st_q == CHECK && !match) err_q <= 1'b1;
      else if (bus.clr_err)        err_q <= 1'b0;
    end
  end

  assign bus.s       = s_q;
  assign bus.r       = r_q;
  assign bus.en      = en_q;
  assign bus.gnt_a   = gnt_a_q;
  assign bus.gnt_b   = gnt_b_q;
  assign bus.busy    = (st_q != IDLE);
  assign bus.err     = err_q;
  assign bus.state_q = val_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl -- two controller instances share the clock: g[0] uses the
// default timing for directed scenarios, g[1] uses PULSE_CYC=1/SETTLE_CYC=3
// under random traffic. Each instance has a latch model, a cycle model and a
// grant scoreboard checked on every falling edge.
module tb_sr_latch_ctrl;

  typedef struct {
    logic who;
    logic cmd;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn    [2];
  logic req_a_d [2], cmd_a_d [2], req_b_d [2], cmd_b_d [2];
  logic clr_d   [2], stuck   [2];
  logic gnt_a_o [2], gnt_b_o [2], en_o [2], s_o [2], r_o [2];
  logic busy_o  [2], err_o   [2], st_o [2];

  int nchk = 0;
  int nerr = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d @%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int P = (k == 0) ? 2 : 1;
    localparam int S = (k == 0) ? 2 : 3;

    sr_latch_ctrl_if bus ();
    sr_latch_ctrl #(.PULSE_CYC(P), .SETTLE_CYC(S)) dut (
      .clk   (clk),
      .rst_n (rstn[k]),
      .bus   (bus)
    );

    // latch model: gated, updates on the clock while en is high
    logic lq = 1'b0;
    always @(posedge clk) begin
      if (bus.en && bus.s)      lq <= 1'b1;
      else if (bus.en && bus.r) lq <= 1'b0;
    end

    assign bus.req_a   = req_a_d[k];
    assign bus.cmd_a   = cmd_a_d[k];
    assign bus.req_b   = req_b_d[k];
    assign bus.cmd_b   = cmd_b_d[k];
    assign bus.clr_err = clr_d[k];
    assign bus.q       = stuck[k] ? 1'b0 : lq;
    assign bus.qbar    = ~bus.q;
    assign gnt_a_o[k]  = bus.gnt_a;
    assign gnt_b_o[k]  = bus.gnt_b;
    assign en_o[k]     = bus.en;
    assign s_o[k]      = bus.s;
    assign r_o[k]      = bus.r;
    assign busy_o[k]   = bus.busy;
    assign err_o[k]    = bus.err;
    assign st_o[k]     = bus.state_q;

    // cycle model: rem counts remaining busy cycles after arbitration
    int   cyc = 0;
    int   rem = 0;
    logic last = 1'b1, m_cmd = 1'b0, mst = 1'b0, merr = 1'b0;
    exp_t sb [$];

    logic win_c, cmd_c, ok_c, e_drv;
    assign win_c = (bus.req_a && bus.req_b) ? ~last : bus.req_b;
    assign cmd_c = win_c ? bus.cmd_b : bus.cmd_a;
    assign ok_c  = (bus.q == m_cmd) && (bus.qbar == ~m_cmd);
    assign e_drv = (rem >= S + 2);

    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rstn[k]) begin
        rem  <= 0;
        last <= 1'b1;
        mst  <= 1'b0;
        merr <= 1'b0;
        sb.delete();
      end else begin
        if (rem == 1 && ok_c) mst <= m_cmd;
        if (rem == 1 && !ok_c) merr <= 1'b1;
        else if (bus.clr_err)  merr <= 1'b0;
        if (rem > 0) rem <= rem - 1;
        else if (bus.req_a || bus.req_b) begin
          last  <= win_c;
          m_cmd <= cmd_c;
          sb.push_back('{win_c, cmd_c, cyc + 1 + P + S});
          rem   <= P + S + 1;
        end
      end
    end

    always @(negedge clk) begin
      if (cyc > 0) begin
        chk_eq($sformatf("busy%0d", k),  bus.busy,    int'(rem != 0));
        chk_eq($sformatf("en%0d", k),    bus.en,      e_drv);
        chk_eq($sformatf("s%0d", k),     bus.s,       e_drv & m_cmd);
        chk_eq($sformatf("r%0d", k),     bus.r,       e_drv & ~m_cmd);
        chk_eq($sformatf("stq%0d", k),   bus.state_q, mst);
        chk_eq($sformatf("err%0d", k),   bus.err,     merr);
        if (bus.gnt_a || bus.gnt_b) begin
          if (sb.size() == 0) begin
            chk_eq($sformatf("gnt_unexp%0d", k), {bus.gnt_b, bus.gnt_a}, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk_eq($sformatf("gnt_who%0d", k), {bus.gnt_b, bus.gnt_a}, e.who ? 2 : 1);
            chk_eq($sformatf("gnt_lat%0d", k), cyc, e.due);
          end
        end else if (sb.size() > 0 && cyc >= sb[0].due) begin
          exp_t e;
          e = sb.pop_front();
          chk_eq($sformatf("gnt_miss%0d", k), {bus.gnt_b, bus.gnt_a}, e.who ? 2 : 1);
        end
      end
    end
  end

  task automatic wait_gnt(input int k, output int who);
    who = -1;
    for (int i = 0; i < 60 && who < 0; i++) begin
      @(negedge clk);
      if (gnt_a_o[k])      who = 0;
      else if (gnt_b_o[k]) who = 1;
    end
    if (who < 0) chk_eq("gnt_timeout", gnt_a_o[k] | gnt_b_o[k], 1);
  endtask

  task automatic pulse_rst(input int k);
    @(negedge clk); rstn[k] = 1'b0;
    @(negedge clk); @(negedge clk); rstn[k] = 1'b1;
  endtask

  initial begin
    int who, t0, found;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; req_a_d[k] = 1'b0; cmd_a_d[k] = 1'b0;
      req_b_d[k] = 1'b0; cmd_b_d[k] = 1'b0; clr_d[k] = 1'b0; stuck[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", busy_o[0], 0);
    chk_eq("rst_err",  err_o[0],  0);
    chk_eq("rst_stq",  st_o[0],   0);
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    @(negedge clk);

    // single set from A
    req_a_d[0] = 1'b1; cmd_a_d[0] = 1'b1;
    t0 = g[0].cyc;
    @(negedge clk);
    chk_eq("t1_en_s", {en_o[0], s_o[0], r_o[0]}, 3'b110);
    wait_gnt(0, who);
    req_a_d[0] = 1'b0;
    chk_eq("t1_who", who, 0);
    chk_eq("t1_lat", g[0].cyc - t0, 5);
    @(negedge clk);
    chk_eq("t1_stq", st_o[0], 1);
    chk_eq("t1_err", err_o[0], 0);

    // contention after reset: A, B, A, B
    pulse_rst(0);
    req_a_d[0] = 1'b1; cmd_a_d[0] = 1'b1;
    req_b_d[0] = 1'b1; cmd_b_d[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(0, who);
      chk_eq($sformatf("rr_order%0d", i), who, i % 2);
    end
    req_a_d[0] = 1'b0; req_b_d[0] = 1'b0;
    @(negedge clk);
    chk_eq("rr_stq", st_o[0], 0);

    // stuck readback on a set, then clear
    stuck[0] = 1'b1;
    req_a_d[0] = 1'b1; cmd_a_d[0] = 1'b1;
    wait_gnt(0, who);
    req_a_d[0] = 1'b0;
    chk_eq("stk_who", who, 0);
    @(negedge clk);
    stuck[0] = 1'b0;
    chk_eq("stk_err", err_o[0], 1);
    chk_eq("stk_stq", st_o[0], 0);
    clr_d[0] = 1'b1;
    @(negedge clk);
    clr_d[0] = 1'b0;
    chk_eq("clr_err", err_o[0], 0);

    // reset in the second DRIVE cycle aborts; A then wins contention
    pulse_rst(0);
    req_a_d[0] = 1'b1; cmd_a_d[0] = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (en_o[0]) found = 1;
    end
    chk_eq("abort_en_seen", en_o[0], 1);
    @(negedge clk);
    rstn[0] = 1'b0; req_a_d[0] = 1'b0;
    @(negedge clk);
    chk_eq("abort_out", {s_o[0], r_o[0], en_o[0], busy_o[0]}, 0);
    rstn[0] = 1'b1;
    repeat (6) @(negedge clk);
    req_a_d[0] = 1'b1; cmd_a_d[0] = 1'b0;
    req_b_d[0] = 1'b1; cmd_b_d[0] = 1'b1;
    wait_gnt(0, who);
    req_a_d[0] = 1'b0; req_b_d[0] = 1'b0;
    chk_eq("abort_next_who", who, 0);

    // random traffic on the PULSE_CYC=1/SETTLE_CYC=3 instance
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (gnt_a_o[1])                                 req_a_d[1] = ($urandom_range(0, 3) == 0);
      else if (!req_a_d[1] && $urandom_range(0, 3) == 0) req_a_d[1] = 1'b1;
      else if (req_a_d[1] && $urandom_range(0, 63) == 0) req_a_d[1] = 1'b0;
      if (gnt_b_o[1])                                 req_b_d[1] = ($urandom_range(0, 3) == 0);
      else if (!req_b_d[1] && $urandom_range(0, 3) == 0) req_b_d[1] = 1'b1;
      else if (req_b_d[1] && $urandom_range(0, 63) == 0) req_b_d[1] = 1'b0;
      cmd_a_d[1] = 1'($urandom_range(0, 1));
      cmd_b_d[1] = 1'($urandom_range(0, 1));
      clr_d[1]   = ($urandom_range(0, 15) == 0);
      stuck[1]   = ($urandom_range(0, 7) == 0);
    end
    req_a_d[1] = 1'b0; req_b_d[1] = 1'b0; clr_d[1] = 1'b0; stuck[1] = 1'b0;
    repeat (12) @(negedge clk);
    chk_eq("end_sb0", g[0].sb.size(), 0);
    chk_eq("end_sb1", g[1].sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 The block SHALL have parameter PULSE_CYC, default 2, giving the drive-pulse length in clk cycles (legal 1..255).
REQ-002 The block SHALL have parameter SETTLE_CYC, default 2, giving the post-pulse settle length in clk cycles (legal 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-005 The block SHALL have port req_a, input, 1 bit: requester A wants a latch write; held high until gnt_a.
REQ-006 The block SHALL have port cmd_a, input, 1 bit: requester A command, 1=set, 0=reset; valid while req_a is high.
REQ-007 The block SHALL have port gnt_a, output, 1 bit: one-cycle completion pulse for requester A.
REQ-008 The block SHALL have ports req_b, cmd_b and gnt_b with the same directions, widths and meaning for requester B.
REQ-009 The block SHALL have ports s and r, outputs, 1 bit each: set and reset drive to the gated SR latch.
REQ-010 The block SHALL have port en, output, 1 bit: gate/clock enable to the latch.
REQ-011 The block SHALL have ports q and qbar, inputs, 1 bit each: latch outputs, read back for checking.
REQ-012 The block SHALL have port clr_err, input, 1 bit: clears err.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port err, output, 1 bit: sticky readback-mismatch flag.
REQ-015 The block SHALL have port state_q, output, 1 bit: last successfully verified latch value.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, SETTLE and CHECK.
REQ-017 In IDLE with any request high, the FSM SHALL register the winner and its cmd, then enter DRIVE on the next cycle.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; the first arbitration after reset favours A.
REQ-019 DRIVE SHALL last exactly PULSE_CYC cycles with en=1, s=cmd and r=~cmd.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles with s=r=en=0.
REQ-021 CHECK SHALL last one cycle: if q==cmd and qbar==~cmd, state_q updates to cmd; otherwise err sets and state_q holds.
REQ-022 The winner's gnt SHALL pulse high only in the CHECK cycle, regardless of the check result.
REQ-023 CHECK SHALL always go to IDLE, so there is at least one IDLE cycle between transactions.
REQ-024 Latency SHALL be fixed: a request seen in IDLE at cycle t gives gnt at cycle t+1+PULSE_CYC+SETTLE_CYC (t+5 at defaults).
REQ-025 s and r SHALL never both be 1, and en SHALL be 1 only in DRIVE.
REQ-026 Outside DRIVE, s, r and en SHALL all be 0.
REQ-027 The cmd captured at arbitration SHALL be used for the whole transaction; cmd or req changes after capture SHALL be ignored.
REQ-028 If the winner drops req mid-transaction, the transaction SHALL complete and gnt SHALL still pulse.
REQ-029 A request still high in the IDLE cycle after its gnt SHALL be treated as a new request.
REQ-030 If clr_err and a mismatch occur in the same cycle, set SHALL win and err SHALL stay 1.
REQ-031 Otherwise, clr_err=1 SHALL clear err on the next edge.
REQ-032 Commands equal to state_q SHALL still execute in full; no command SHALL be skipped.
REQ-033 Phase counters SHALL be 8 bits wide and SHALL reload on every state entry.

Reset
REQ-034 When rst_n=0 at an edge, the block SHALL enter IDLE with s=r=en=0, gnt_a=gnt_b=0, busy=0, err=0, state_q=0 and priority set to A.
REQ-035 A reset during DRIVE, SETTLE or CHECK SHALL abort the transaction with no gnt pulse, and outputs SHALL drop on that edge.

Verification
REQ-036 Bench SHALL apply: reset, then req_a=1, cmd_a=1 with latch model -> s=1, en=1 for 2 cycles; gnt_a at t+5; state_q=1; err=0.
REQ-037 Bench SHALL apply: req_a and req_b held high together -> grant order A, B, A, B; each gnt one cycle; transactions separated by one IDLE cycle.
REQ-038 Bench SHALL apply: q stuck at 0 during a set command -> err=1, state_q=0, gnt still pulses; then clr_err=1 -> err=0 next cycle.
REQ-039 Bench SHALL apply: rst_n=0 in the second DRIVE cycle -> s=r=en=0 and busy=0 after that edge; no gnt; the next request is granted to A.
REQ-040 Bench SHALL run with PULSE_CYC=1, SETTLE_CYC=3 and random req/cmd stimulus for at least 10k cycles -> latency always 5, s&r never both 1, en high only in DRIVE.
